// File: rtl/swg_pkg.sv
// Sliding-window generator shared helpers.
// Output-dimension math and out_win element packing index.
package swg_pkg;

  function automatic int out_dim(input int n, input int k,
                                 input int s, input int p);
    return (n + 2 * p - k) / s + 1;
  endfunction

  function automatic int elem_idx(input int ky, input int kx,
                                  input int c, input int k,
                                  input int nf, input int bw);
    return ((ky * k + kx) * nf + c) * bw;
  endfunction

endpackage

// File: rtl/swg_line_store.sv
// K-row circular line store indexed by padded column.
// Ports: i_we/i_col/i_din write, i_eol rotates rows, o_col = column ky=0..K-1.
module swg_line_store
  import swg_pkg::*;
#(
  parameter int K   = 3,
  parameter int PXW = 128,
  parameter int PW  = 30,
  parameter int CW  = 5
)(
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_clr,
  input  logic           i_we,
  input  logic           i_eol,
  input  logic [CW-1:0]  i_col,
  input  logic [PXW-1:0] i_din,
  output logic [K*PXW-1:0] o_col
);
  localparam int PTW = (K > 1) ? $clog2(K) : 1;

  logic [PXW-1:0] r_mem [K][PW];
  logic [PTW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_ptr <= '0;
    else if (i_clr)
      r_ptr <= '0;
    else if (i_we && i_eol)
      r_ptr <= (r_ptr == PTW'(K - 1)) ? '0 : r_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[r_ptr][i_col] <= i_din;
  end

  // Row ky of the window is K-1-ky rows older than the row
  // being written; the newest row comes straight from i_din.
  always_comb begin
    o_col = '0;
    for (int ky = 0; ky < K; ky++) begin
      int s;
      s = int'(r_ptr) + ky + 1;
      if (s >= K)
        s = s - K;
      if (ky == K - 1)
        o_col[ky*PXW +: PXW] = i_din;
      else
        o_col[ky*PXW +: PXW] = r_mem[s[PTW-1:0]][i_col];
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Streams pixels in, emits KxK windows over a zero-padded frame.
// Ports: in_valid/in_data/in_ready, out_valid/out_win/out_last/out_ready, clear.
module sliding_window_gen
  import swg_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 16,
  parameter int NFMAPS   = 8,
  parameter int STRIDE   = 1,
  parameter int PAD      = 1,
  parameter int NW       = 28,
  parameter int NH       = 28
)(
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic in_valid,
  input  logic [NFMAPS*BITWIDTH-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH-1:0] out_win,
  input  logic out_ready,
  output logic out_last
);
  localparam int K   = KER_SIZE;
  localparam int S   = STRIDE;
  localparam int P   = PAD;
  localparam int PXW = NFMAPS * BITWIDTH;
  localparam int PW  = NW + 2 * P;
  localparam int PH  = NH + 2 * P;
  localparam int CW  = ($clog2(PW) > 0) ? $clog2(PW) : 1;
  localparam int RW  = ($clog2(PH) > 0) ? $clog2(PH) : 1;
  localparam int SW  = (S > 1) ? $clog2(S) : 1;
  localparam int OH  = out_dim(NH, K, S, P);
  localparam int OW  = out_dim(NW, K, S, P);
  localparam int LROW = K - 1 + (OH - 1) * S;
  localparam int LCOL = K - 1 + (OW - 1) * S;
  localparam logic [SW-1:0] PHM = SW'(S - 1);

  logic [RW-1:0] r_prow, w_prow_n;
  logic [CW-1:0] r_pcol, w_pcol_n;
  logic [SW-1:0] r_rph, w_rph_n;
  logic [SW-1:0] r_cph, w_cph_n;
  logic          r_en;
  logic          w_pad, w_stall, w_adv;
  logic          w_eol, w_eof, w_emit, w_last;
  logic [PXW-1:0]     w_pix;
  logic [K*PXW-1:0]   w_col;
  logic [K*K*PXW-1:0] w_win, r_win;

  assign w_pad = (int'(r_prow) < P) || (int'(r_prow) >= NH + P) ||
                 (int'(r_pcol) < P) || (int'(r_pcol) >= NW + P);
  assign w_stall  = out_valid && !out_ready;
  // r_en keeps the pipe idle (and in_ready low) while in reset.
  assign in_ready = r_en && !w_pad && !w_stall;
  assign w_adv    = r_en && !clear && (w_pad || in_valid) && !w_stall;
  assign w_pix    = w_pad ? '0 : in_data;
  assign w_eol    = (int'(r_pcol) == PW - 1);
  assign w_eof    = w_eol && (int'(r_prow) == PH - 1);
  assign w_emit   = (int'(r_prow) >= K - 1) && (int'(r_pcol) >= K - 1) &&
                    (r_rph == '0) && (r_cph == '0);
  assign w_last   = (int'(r_prow) == LROW) && (int'(r_pcol) == LCOL);
  assign out_win  = r_win;

  // Phase counters are held at zero up to K-1, then count mod S.
  always_comb begin
    w_pcol_n = w_eol ? '0 : r_pcol + 1'b1;
    w_prow_n = r_prow;
    w_rph_n  = r_rph;
    if (w_eol) begin
      w_prow_n = w_eof ? '0 : r_prow + 1'b1;
      w_rph_n  = (int'(w_prow_n) <= K - 1) ? '0 :
                 (r_rph == PHM) ? '0 : r_rph + 1'b1;
    end
    w_cph_n = (int'(w_pcol_n) <= K - 1) ? '0 :
              (r_cph == PHM) ? '0 : r_cph + 1'b1;
  end

  swg_line_store #(
    .K(K), .PXW(PXW), .PW(PW), .CW(CW)
  ) u_ls (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (clear),
    .i_we  (w_adv),
    .i_eol (w_eol),
    .i_col (r_pcol),
    .i_din (w_pix),
    .o_col (w_col)
  );

  // Window register shifts left one column per advance; the
  // freshly read column enters at kx=K-1.
  for (genvar ky = 0; ky < K; ky++) begin : g_ky
    for (genvar kx = 0; kx < K; kx++) begin : g_kx
      localparam int B = elem_idx(ky, kx, 0, K, NFMAPS, BITWIDTH);
      if (kx == K - 1) begin : g_new
        assign w_win[B +: PXW] = w_col[ky*PXW +: PXW];
      end else begin : g_sh
        assign w_win[B +: PXW] = r_win[B+PXW +: PXW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en      <= 1'b0;
      r_prow    <= '0;
      r_pcol    <= '0;
      r_rph     <= '0;
      r_cph     <= '0;
      r_win     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (clear) begin
        r_prow    <= '0;
        r_pcol    <= '0;
        r_rph     <= '0;
        r_cph     <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (w_adv) begin
          r_prow <= w_prow_n;
          r_pcol <= w_pcol_n;
          r_rph  <= w_rph_n;
          r_cph  <= w_cph_n;
          r_win  <= w_win;
        end
        if (w_adv && w_emit) begin
          out_valid <= 1'b1;
          out_last  <= w_last;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule
